ebus_arb: RTL and testbench

- Arbitrates the EBUS among NREQ requesters (CTL diagnostic path, APR, PI, console) and sequences one EBUS transfer per grant.
- Owns the timing of EBUS_DS_STROBE: grant, setup, strobe, wait for transfer acknowledge, hold, release.
- Sits beside CTL and the other EBUS drivers. CTL consumes EBUS_DS_STROBE and the granted function code.

---
 rtl/ebus_arb.sv | 194 +++++++++++++++++++
 tb/tb_ebus_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_arb.sv
// EBUS arbiter: round-robin grant among NREQ requesters and sequencing of one strobed transfer per grant.
// Optional EBUS_TIMEOUT_EN adds an acknowledge timeout that releases the bus with an err pulse.
module ebus_arb #(
    parameter int NREQ     = 4,
    parameter int SETUP    = 2,
    parameter int STROBE_W = 2,
    parameter int HOLD     = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic              eboxClk,
    input  logic              eboxReset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*7-1:0] reqFunc,
    output logic [NREQ-1:0]   grant,
    output logic [6:0]        EBUS_DS,
    output logic              EBUS_DS_STROBE,
    input  logic              EBUS_XFER,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              busy
);
    localparam int PW = $clog2(NREQ);
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_W - 1);
    // HOLD=0 still spends one cycle in HOLD before RELEASE
    localparam logic [3:0] HOLD_LAST   = (HOLD == 0) ? 4'd0 : 4'(HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_HOLD, ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [6:0]        ds_q, ds_d;
    logic [PW-1:0]     win_q, win_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              xfer_seen_q, xfer_seen_d;
    logic              arb_found;
    logic [PW-1:0]     arb_idx;
    logic [NREQ-1:0]   arb_onehot;
    logic [6:0]        arb_func;

`ifdef EBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              err_pend_q, err_pend_d;
`else
    if (TIMEOUT < 2) begin : g_timeout_unused
    end
`endif

    // Two passes: indices at/after the pointer first, then wrap to those below it.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        arb_func   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!arb_found && req[j] && (j >= int'(ptr_q))) begin
                arb_found     = 1'b1;
                arb_idx       = PW'(j);
                arb_onehot[j] = 1'b1;
                arb_func      = reqFunc[j*7 +: 7];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!arb_found && req[j]) begin
                arb_found     = 1'b1;
                arb_idx       = PW'(j);
                arb_onehot[j] = 1'b1;
                arb_func      = reqFunc[j*7 +: 7];
            end
        end
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            ds_q        <= '0;
            win_q       <= '0;
            ptr_q       <= '0;
            xfer_seen_q <= 1'b0;
`ifdef EBUS_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            ds_q        <= ds_d;
            win_q       <= win_d;
            ptr_q       <= ptr_d;
            xfer_seen_q <= xfer_seen_d;
`ifdef EBUS_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            err_pend_q  <= err_pend_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        ds_d        = ds_q;
        win_d       = win_q;
        ptr_d       = ptr_q;
        xfer_seen_d = xfer_seen_q;
        case (state_q)
            ST_IDLE: begin
                xfer_seen_d = 1'b0;
                if (arb_found) begin
                    grant_d = arb_onehot;
                    ds_d    = arb_func;
                    win_d   = arb_idx;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STROBE: begin
                if (EBUS_XFER) xfer_seen_d = 1'b1;
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT: begin
                if (EBUS_XFER || xfer_seen_q) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RELEASE: begin
                grant_d     = '0;
                ds_d        = '0;
                xfer_seen_d = 1'b0;
                ptr_d       = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef EBUS_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_pend_d = 1'b0;
        if (state_q == ST_SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == ST_STROBE || state_q == ST_WAIT) begin
            if (!EBUS_XFER && !xfer_seen_q && to_cnt_q == TO_LAST) begin
                state_d    = ST_RELEASE;
                err_pend_d = 1'b1;
                cnt_d      = '0;
            end else if (to_cnt_q != TO_LAST) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        grant          = grant_q;
        EBUS_DS        = ds_q;
        EBUS_DS_STROBE = (state_q == ST_STROBE);
        busy           = (state_q != ST_IDLE);
        done           = (state_q == ST_RELEASE) ? grant_q : '0;
`ifdef EBUS_TIMEOUT_EN
        err            = err_pend_q ? done : '0;
`else
        err            = '0;
`endif
    end
endmodule

// File: tb/tb_ebus_arb.sv
// Directed bench for ebus_arb: single transfer, contention, early ack, request drop, reset, timeout.
module tb_ebus_arb;
    logic        eboxClk = 1'b0;
    logic        eboxReset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] reqFunc = '0;
    logic [3:0]  grant;
    logic [6:0]  EBUS_DS;
    logic        EBUS_DS_STROBE;
    logic        EBUS_XFER = 1'b0;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    int vectors = 0;
    int miscompares = 0;

    ebus_arb #(.NREQ(4), .SETUP(2), .STROBE_W(2), .HOLD(1), .TIMEOUT(8)) dut (
        .eboxClk(eboxClk), .eboxReset_n(eboxReset_n), .req(req), .reqFunc(reqFunc),
        .grant(grant), .EBUS_DS(EBUS_DS), .EBUS_DS_STROBE(EBUS_DS_STROBE),
        .EBUS_XFER(EBUS_XFER), .done(done), .err(err), .busy(busy)
    );

    always #5 eboxClk = ~eboxClk;

    task automatic do_reset();
        @(negedge eboxClk);
        eboxReset_n = 1'b0;
        req = '0;
        EBUS_XFER = 1'b0;
        repeat (2) @(negedge eboxClk);
        eboxReset_n = 1'b1;
    endtask

    task automatic test_reset();
        eboxReset_n = 1'b0;
        repeat (2) @(negedge eboxClk);
        vectors++;
        if ({grant, EBUS_DS, EBUS_DS_STROBE, done, err, busy} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got grant=%b ds=%o stb=%b done=%b err=%b busy=%b want all 0",
                     grant, EBUS_DS, EBUS_DS_STROBE, done, err, busy);
        end
        eboxReset_n = 1'b1;
        repeat (2) @(negedge eboxClk);
        vectors++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b grant=%b want 0 0000", busy, grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        reqFunc[7 +: 7] = 7'o071;
        req = 4'b0010;
        @(negedge eboxClk);
        vectors++;
        if (grant !== 4'b0010 || EBUS_DS !== 7'o071) begin
            miscompares++;
            $display("FAIL single_grant got grant=%b ds=%o want 0010 71", grant, EBUS_DS);
        end
        vectors++;
        if (EBUS_DS_STROBE !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_setup got stb=%b busy=%b want 0 1", EBUS_DS_STROBE, busy);
        end
        @(negedge eboxClk);
        vectors++;
        if (EBUS_DS_STROBE !== 1'b0) begin
            miscompares++;
            $display("FAIL single_setup2 got stb=%b want 0", EBUS_DS_STROBE);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge eboxClk);
            vectors++;
            if (EBUS_DS_STROBE !== 1'b1) begin
                miscompares++;
                $display("FAIL single_strobe%0d got %b want 1", i, EBUS_DS_STROBE);
            end
        end
        @(negedge eboxClk);
        vectors++;
        if (EBUS_DS_STROBE !== 1'b0) begin
            miscompares++;
            $display("FAIL single_strobe_end got %b want 0", EBUS_DS_STROBE);
        end
        @(negedge eboxClk);
        EBUS_XFER = 1'b1;
        @(negedge eboxClk);
        EBUS_XFER = 1'b0;
        vectors++;
        if (done !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_hold_done got %b want 0000", done);
        end
        @(negedge eboxClk);
        vectors++;
        if (done !== 4'b0010 || EBUS_DS !== 7'o071 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done got done=%b ds=%o busy=%b want 0010 71 1", done, EBUS_DS, busy);
        end
        req = '0;
        @(negedge eboxClk);
        vectors++;
        if (busy !== 1'b0 || done !== 4'b0000 || grant !== 4'b0000 || EBUS_DS !== 7'o000) begin
            miscompares++;
            $display("FAIL single_after got busy=%b done=%b grant=%b ds=%o want 0 0000 0000 0",
                     busy, done, grant, EBUS_DS);
        end
    endtask

    task automatic test_contention();
        logic [3:0] prev;
        logic [3:0] exp_g [5];
        int n;
        int gap;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n = 0;
        gap = 0;
        prev = '0;
        do_reset();
        req = 4'b1111;
        EBUS_XFER = 1'b1;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge eboxClk);
            if (grant !== 4'b0000 && prev === 4'b0000) begin
                vectors++;
                if (grant !== exp_g[n]) begin
                    miscompares++;
                    $display("FAIL contention_order%0d got %b want %b", n, grant, exp_g[n]);
                end
                if (n > 0) begin
                    vectors++;
                    if (gap !== 1) begin
                        miscompares++;
                        $display("FAIL contention_gap%0d got %0d want 1", n, gap);
                    end
                end
                n++;
                gap = 0;
            end else if (grant === 4'b0000) begin
                gap++;
            end
            prev = grant;
        end
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL contention_count got %0d grants want 5", n);
        end
        req = '0;
        EBUS_XFER = 1'b0;
    endtask

    task automatic test_early_ack();
        do_reset();
        reqFunc[0 +: 7] = 7'o123;
        req = 4'b0001;
        repeat (4) @(negedge eboxClk);
        EBUS_XFER = 1'b1;
        @(negedge eboxClk);
        EBUS_XFER = 1'b0;
        vectors++;
        if (EBUS_DS_STROBE !== 1'b0 || done !== 4'b0000) begin
            miscompares++;
            $display("FAIL early_wait got stb=%b done=%b want 0 0000", EBUS_DS_STROBE, done);
        end
        @(negedge eboxClk);
        vectors++;
        if (done !== 4'b0000) begin
            miscompares++;
            $display("FAIL early_hold got done=%b want 0000", done);
        end
        @(negedge eboxClk);
        req = '0;
        vectors++;
        if (done !== 4'b0001 || EBUS_DS !== 7'o123) begin
            miscompares++;
            $display("FAIL early_done got done=%b ds=%o want 0001 123", done, EBUS_DS);
        end
        @(negedge eboxClk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL early_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_drop();
        do_reset();
        reqFunc[14 +: 7] = 7'o055;
        req = 4'b0100;
        @(negedge eboxClk);
        vectors++;
        if (grant !== 4'b0100 || EBUS_DS !== 7'o055) begin
            miscompares++;
            $display("FAIL drop_grant got grant=%b ds=%o want 0100 55", grant, EBUS_DS);
        end
        req = '0;
        reqFunc[14 +: 7] = 7'o077;
        EBUS_XFER = 1'b1;
        @(negedge eboxClk);
        EBUS_XFER = 1'b0;
        vectors++;
        if (EBUS_DS !== 7'o055) begin
            miscompares++;
            $display("FAIL drop_ds_setup got %o want 55", EBUS_DS);
        end
        @(negedge eboxClk);
        vectors++;
        if (EBUS_DS_STROBE !== 1'b1 || EBUS_DS !== 7'o055) begin
            miscompares++;
            $display("FAIL drop_strobe got stb=%b ds=%o want 1 55", EBUS_DS_STROBE, EBUS_DS);
        end
        repeat (3) @(negedge eboxClk);
        vectors++;
        if (busy !== 1'b1 || done !== 4'b0000) begin
            miscompares++;
            $display("FAIL drop_setup_ack_ignored got busy=%b done=%b want 1 0000", busy, done);
        end
        EBUS_XFER = 1'b1;
        @(negedge eboxClk);
        EBUS_XFER = 1'b0;
        @(negedge eboxClk);
        vectors++;
        if (done !== 4'b0100 || EBUS_DS !== 7'o055) begin
            miscompares++;
            $display("FAIL drop_done got done=%b ds=%o want 0100 55", done, EBUS_DS);
        end
        @(negedge eboxClk);
        vectors++;
        if (grant !== 4'b0000 || EBUS_DS !== 7'o000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_release got grant=%b ds=%o busy=%b want 0000 0 0", grant, EBUS_DS, busy);
        end
    endtask

    // Runs right after test_drop so the pointer is 3 before the reset.
    task automatic test_reset_mid();
        reqFunc[21 +: 7] = 7'o013;
        req = 4'b1000;
        @(negedge eboxClk);
        vectors++;
        if (grant !== 4'b1000) begin
            miscompares++;
            $display("FAIL rmid_grant got %b want 1000", grant);
        end
        repeat (2) @(negedge eboxClk);
        vectors++;
        if (EBUS_DS_STROBE !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_strobe got %b want 1", EBUS_DS_STROBE);
        end
        #2 eboxReset_n = 1'b0;
        #1;
        vectors++;
        if (EBUS_DS_STROBE !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0 || EBUS_DS !== 7'o000 || done !== 4'b0000) begin
            miscompares++;
            $display("FAIL rmid_async got stb=%b grant=%b busy=%b ds=%o done=%b want 0 0000 0 0 0000",
                     EBUS_DS_STROBE, grant, busy, EBUS_DS, done);
        end
        req = 4'b1001;
        repeat (2) @(negedge eboxClk);
        eboxReset_n = 1'b1;
        @(negedge eboxClk);
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL rmid_pointer got %b want 0001", grant);
        end
        req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        repeat (3) @(negedge eboxClk);
        vectors++;
        if (EBUS_DS_STROBE !== 1'b1) begin
            miscompares++;
            $display("FAIL to_strobe got %b want 1", EBUS_DS_STROBE);
        end
`ifdef EBUS_TIMEOUT_EN
        repeat (7) @(negedge eboxClk);
        vectors++;
        if (done !== 4'b0000 || err !== 4'b0000) begin
            miscompares++;
            $display("FAIL to_early got done=%b err=%b want 0000 0000", done, err);
        end
        @(negedge eboxClk);
        req = '0;
        vectors++;
        if (done !== 4'b0001 || err !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_pulse got done=%b err=%b want 0001 0001", done, err);
        end
        @(negedge eboxClk);
        vectors++;
        if (busy !== 1'b0 || err !== 4'b0000) begin
            miscompares++;
            $display("FAIL to_idle got busy=%b err=%b want 0 0000", busy, err);
        end
`else
        for (int c = 0; c < 100; c++) begin
            @(negedge eboxClk);
            if (c == 8 || c == 99) begin
                vectors++;
                if (busy !== 1'b1 || err !== 4'b0000 || done !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL noto_wait%0d got busy=%b err=%b done=%b want 1 0000 0000",
                             c, busy, err, done);
                end
            end
        end
        req = '0;
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_early_ack();
        test_drop();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
